up5bit_counter_sched: RTL
=========================

Name: up5bit_counter_sched

Overview:
Round-robin scheduler that shares one 5-bit up-counter (up5bit_counter class datapath) between NREQ requesters.
Each requester asks for a timed interval of req_len counts.
The block grants the counter to one requester at a time, clears it, enables it until the requested count is reached, then pulses done.
It sits between client logic and the counter instance; the counter itself stays external.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 5, counter/length width in bits; must match the counter instance

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req  input  NREQ  per-requester level request; held until done or withdrawn
req_len  input  NREQ*WIDTH  packed lengths; slice i = req_len[i*WIDTH +: WIDTH]; sampled at grant
grant  output  NREQ  one-hot; owner of the counter, asserted CLEAR..DONE inclusive
done  output  NREQ  one-cycle pulse to owner on completed interval
busy  output  1  high whenever state != IDLE
cnt_clr  output  1  synchronous clear to counter
cnt_en  output  1  count enable to counter
cnt_val  input  WIDTH  current counter value (registered counter output)

Behaviour:
- Reset (sync, active-high): state=IDLE; grant=0, done=0, busy=0, cnt_clr=0, cnt_en=0; rr pointer=0; latched len=0. Reset mid-run aborts immediately: no done pulse, counter left as-is.
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE: if |req, select the winner by round-robin. Search starts at index ptr and wraps modulo NREQ. Latch the index and its req_len slice. Next state is CLEAR. If req==0, stay in IDLE.
- CLEAR (1 cycle): cnt_clr=1, cnt_en=0, grant[idx]=1. Next state is RUN; cnt_val=0 in the first RUN cycle.
- RUN: cnt_en = (cnt_val != len), combinational. When cnt_val==len, next state is DONE. If req[idx]==0 in RUN, next state is IDLE (abort): no done pulse, grant drops next cycle.
- DONE (1 cycle): done[idx]=1, grant[idx]=1, cnt_en=0. Next state is IDLE.
- Round-robin pointer: ptr <= idx+1 (mod NREQ) on leaving DONE or on abort.
- Latency: req seen in IDLE at cycle 0 -> CLEAR at 1 -> RUN cycles 2..L+2 -> DONE at L+3. Exactly L cycles of cnt_en=1.
- len=0: one RUN cycle with cnt_en=0, done at cycle 3.
- len=31 (max): counter stops at 31 and never wraps. No arithmetic overflow, since only equality compare is used.
- Minimum gap between grants: one IDLE cycle.
- req_len changes after grant are ignored.
- Simultaneous requests: the lowest index at or after ptr wins.
- A requester re-asserting immediately after its done waits behind the others at the next arbitration.
- cnt_clr and cnt_en are never both 1. grant is always one-hot or zero.

Optional Feature:
Macro: UP5BIT_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority, where the lowest requesting index always wins; ptr is unused and held at 0.
- Undefined: round-robin as above.

Decomposition:
- Package up5bit_sched_pkg: state_t enum {IDLE, CLEAR, RUN, DONE}; localparam CNT_WIDTH=5; helper function for slicing req_len.
- Sub-module rr_arbiter (inputs req and ptr; outputs one-hot gnt and encoded idx). It holds the round-robin search and the fixed-priority variant under the macro.
- The FSM and length latch stay in the top module.

Test Plan:
1. Single request: req=0001, len0=5.
   - grant[0] rises cycle 1; cnt_clr=1 at cycle 1.
   - cnt_en high exactly 5 cycles; cnt_val ends at 5.
   - done[0] pulses at cycle 8; busy low at cycle 9.
2. Contention: req=1111, lens 2/3/1/4 held.
   - Grant order is 0,1,2,3, then 0 again.
   - Each done has its exact L+3 latency; grant is never multi-hot.
3. Boundaries: len=0 gives done at cycle 3 with zero cnt_en cycles. len=31 gives cnt_val reaching 31, done at cycle 34, and no wrap to 0.
4. Abort: req[2] (len 10) drops at RUN cycle 4.
   - No done[2]; state returns to IDLE; ptr moves to 3.
   - A pending req[1] is granted next, after req[3] if req[3] is pending.
5. Reset mid-RUN: assert reset at cnt_val=3.
   - All outputs are 0 on the next edge; no done pulse.
   - After release, the first request is granted by index from ptr=0.
6. With UP5BIT_SCHED_FIXED_PRIO_EN: req=0110 held continuously gives index 1 granted repeatedly and index 2 starved. A bench check flags this as expected.

Source files
------------

// File: rtl/up5bit_sched_pkg.sv
// Shared types and helpers for the 5-bit counter scheduler.
// Optional build macro: UP5BIT_SCHED_FIXED_PRIO_EN (fixed-priority arbitration).
package up5bit_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int CNT_WIDTH = 5;
    localparam int MAX_NREQ  = 8;

    // Extract one requester's length from the packed length bus.
    function automatic logic [CNT_WIDTH-1:0] len_slice(
        input logic [MAX_NREQ*CNT_WIDTH-1:0] lens,
        input logic [2:0]                    sel
    );
        return lens[int'(sel)*CNT_WIDTH +: CNT_WIDTH];
    endfunction

endpackage

// File: rtl/up5bit_counter_sched_rr_arbiter.sv
// Combinational requester selection: round-robin starting at ptr, or
// lowest-index-wins when UP5BIT_SCHED_FIXED_PRIO_EN is defined.
module rr_arbiter
    import up5bit_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx
);

    logic          found;
    logic [PW:0]   sum;
    logic [PW-1:0] cur;

    // Walk the requesters in priority order and keep the first one asserted.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        cur   = '0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef UP5BIT_SCHED_FIXED_PRIO_EN
            sum = (PW+1)'(k);
`else
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
`endif
            cur = sum[PW-1:0];
            if (!found && req[cur]) begin
                found = 1'b1;
                idx   = cur;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
            assign gnt[gi] = found && (idx == PW'(gi));
        end
    endgenerate

endmodule

// File: rtl/up5bit_counter_sched.sv
// Shares one external 5-bit up-counter between NREQ requesters. The owner gets
// the counter cleared, counted up to its latched length, then a done pulse.
// Optional build macro: UP5BIT_SCHED_FIXED_PRIO_EN (fixed priority, ptr held 0).
module up5bit_counter_sched
    import up5bit_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_len,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  cnt_clr,
    output logic                  cnt_en,
    input  logic [WIDTH-1:0]      cnt_val
);

    localparam int PW = $clog2(NREQ);

    state_t                         state_reg, state_next;
    logic [PW-1:0]                  idx_reg, idx_next;
    logic [PW-1:0]                  ptr_reg, ptr_next;
    logic [WIDTH-1:0]               len_reg, len_next;
    logic [PW-1:0]                  ptr_inc;
    logic [NREQ-1:0]                arb_gnt;
    logic [PW-1:0]                  arb_idx;
    logic [NREQ-1:0]                owner_oh;
    logic [MAX_NREQ*CNT_WIDTH-1:0]  lens_ext;
    logic [WIDTH-1:0]               len_pick;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req (req),
        .ptr (ptr_reg),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign lens_ext = (MAX_NREQ*CNT_WIDTH)'(req_len);
    assign len_pick = WIDTH'(len_slice(lens_ext, 3'(arb_idx)));
    assign busy     = (state_reg != IDLE);

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_owner
            assign owner_oh[gi] = (idx_reg == PW'(gi));
        end
    endgenerate

    // Pointer value to use once the current owner is finished or withdraws.
    always_comb begin
`ifdef UP5BIT_SCHED_FIXED_PRIO_EN
        ptr_inc = '0;
`else
        ptr_inc = (idx_reg == PW'(NREQ-1)) ? '0 : idx_reg + PW'(1);
`endif
    end

    // State, owner, pointer and latched length registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            ptr_reg   <= '0;
            len_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            ptr_reg   <= ptr_next;
            len_reg   <= len_next;
        end
    end

    // Next-state and output decode; counter enable follows cnt_val directly.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        ptr_next   = ptr_reg;
        len_next   = len_reg;
        grant      = '0;
        done       = '0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|arb_gnt) begin
                    idx_next   = arb_idx;
                    len_next   = len_pick;
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                cnt_clr    = 1'b1;
                grant      = owner_oh;
                state_next = RUN;
            end
            RUN: begin
                grant  = owner_oh;
                cnt_en = (cnt_val != len_reg);
                if (!req[idx_reg]) begin
                    // Owner withdrew: release without a done pulse.
                    state_next = IDLE;
                    ptr_next   = ptr_inc;
                end else if (cnt_val == len_reg) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                grant      = owner_oh;
                done       = owner_oh;
                state_next = IDLE;
                ptr_next   = ptr_inc;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
